// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks:
// FSM state encoding and the default operand width.
package serial_arith_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, with borrow-out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b LSB first, one bit per clock,
// then pulses done for one cycle with diff/borrow valid.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy,
    output logic             done
);

    // One spare bit so the counter can never wrap within an operation.
    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_bin;
    logic [CntW-1:0]  r_cnt;
    logic             w_d;
    logic             w_bout;
    logic             w_accept;
    logic             w_last;

    full_subtractor u_fs (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .bin  (r_bin),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_accept = (r_state == StIdle) && start;
    assign w_last   = (r_cnt == CntW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (start)  w_state_next = StRun;
            StRun:   if (w_last) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Result fills from the MSB end so after WIDTH shifts bit 0 lands in r_res[0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_bin <= 1'b0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_res <= '0;
            r_bin <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == StRun) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= {w_d, r_res[WIDTH-1:1]};
            r_bin <= w_bout;
            r_cnt <= r_cnt + CntW'(1);
        end
    end

    assign diff   = r_res;
    assign borrow = r_bin;
    assign busy   = (r_state != StIdle);
    assign done   = (r_state == StDone);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, corner-case
// sequences and random operands against an arithmetic reference.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
    logic         busy;
    logic         done;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         br;
    } vec_t;

    vec_t vecs[5];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .diff   (diff),
        .borrow (borrow),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at the first negedge after the accepting edge, with start already low.
    task automatic wait_result(input string name, input logic [W-1:0] ed, input logic eb);
        int j;
        int nbusy;
        j     = 0;
        nbusy = busy ? 1 : 0;
        while (!done && j < 4 * W) begin
            @(negedge clk);
            j++;
            if (busy) nbusy++;
        end
        check({name, " latency"}, j, W);
        check({name, " diff"}, diff, ed);
        check({name, " borrow"}, borrow, eb);
        @(negedge clk);
        if (busy) nbusy++;
        check({name, " busy cycles"}, nbusy, W + 1);
        check({name, " done width"}, done, 0);
        check({name, " diff held"}, diff, ed);
        check({name, " borrow held"}, borrow, eb);
    endtask

    task automatic do_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic [W-1:0] ed, input logic eb);
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb_;
        @(negedge clk);
        start = 1'b0;
        wait_result(name, ed, eb);
    endtask

    initial begin
        int ndone;
        int done_at;
        int last;
        int ra;
        int rb;

        vecs[0] = '{a: 8'd100, b: 8'd37,  d: 8'd63,   br: 1'b0};
        vecs[1] = '{a: 8'd37,  b: 8'd100, d: 8'hC1,   br: 1'b1};
        vecs[2] = '{a: 8'd0,   b: 8'd1,   d: 8'hFF,   br: 1'b1};
        vecs[3] = '{a: 8'd255, b: 8'd255, d: 8'h00,   br: 1'b0};
        vecs[4] = '{a: 8'd0,   b: 8'd0,   d: 8'h00,   br: 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("reset diff", diff, 0);
        check("reset borrow", borrow, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br);
        end

        // start re-asserted mid-RUN with different operands must be ignored
        @(negedge clk);
        start = 1'b1;
        a     = 8'd100;
        b     = 8'd37;
        @(negedge clk);
        start   = 1'b0;
        ndone   = 0;
        done_at = -1;
        for (int t = 1; t <= W + 6; t++) begin
            if (t == 3) begin
                start = 1'b1;
                a     = 8'd5;
                b     = 8'd9;
            end
            if (t == 5) start = 1'b0;
            @(negedge clk);
            if (done) begin
                ndone++;
                done_at = t;
                check("restart-ignored diff", diff, 63);
                check("restart-ignored borrow", borrow, 0);
            end
        end
        check("restart-ignored done count", ndone, 1);
        check("restart-ignored done time", done_at, W);

        // reset mid-RUN after bit 3 has been processed
        @(negedge clk);
        start = 1'b1;
        a     = 8'd0;
        b     = 8'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrun rst diff", diff, 0);
        check("midrun rst borrow", borrow, 0);
        check("midrun rst busy", busy, 0);
        check("midrun rst done", done, 0);
        @(negedge clk);
        check("rst held busy", busy, 0);
        check("rst held done", done, 0);
        rst   = 1'b0;
        start = 1'b1;
        a     = 8'd100;
        b     = 8'd37;
        @(negedge clk);
        start = 1'b0;
        check("accept first edge after rst", busy, 1);
        wait_result("post-rst 100-37", 8'd63, 1'b0);

        // start held high: back-to-back operations
        @(negedge clk);
        start = 1'b1;
        a     = 8'd37;
        b     = 8'd100;
        ndone = 0;
        last  = -1;
        for (int t = 0; t <= 3 * W + 6; t++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                check("held-start diff", diff, 8'hC1);
                check("held-start borrow", borrow, 1);
                if (last >= 0) check("held-start period", t - last, W + 2);
                last = t;
            end
        end
        check("held-start done count", ndone, 3);
        start = 1'b0;
        repeat (W + 4) @(negedge clk);
        check("held-start settles idle", busy, 0);

        for (int i = 0; i < 40; i++) begin
            ra = int'($urandom_range(0, (1 << W) - 1));
            rb = int'($urandom_range(0, (1 << W) - 1));
            do_op($sformatf("rand %0d-%0d", ra, rb), W'(ra), W'(rb),
                  W'((ra - rb) & ((1 << W) - 1)), (ra < rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
